// File: rtl/tone_sequencer.sv
// Eight-entry rate/rest pattern player that feeds the tone datapath and gates PDM.
// Define SEQ_GAP_EN to end every step with one silent tick (GAP state).
module tone_sequencer #(
  parameter int STEPS    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [4:0]               wr_data,
  input  logic                     run,
  input  logic [7:0]               step_len,
  output logic [3:0]               rate_out,
  output logic                     gate,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_strobe,
  output logic                     busy
);

  localparam int IW = $clog2(STEPS);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
`ifdef SEQ_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd3;
`endif

  logic [1:0]    state;
  logic [4:0]    pattern [STEPS];
  logic [4:0]    entry;
  logic [PW-1:0] pre;
  logic [8:0]    cnt;
  logic [8:0]    eff_len;
  logic          tick;
  logic          last;

  assign entry   = pattern[step_idx];
  assign tick    = (pre == PW'(TICK_DIV - 1));
  // a zero length encodes the full 256-tick step
  assign eff_len = (step_len == 8'd0) ? 9'd256 : {1'b0, step_len};
  assign last    = ((cnt + 9'd1) >= eff_len);
  assign busy    = (state != S_IDLE);

  // pattern storage survives reset on purpose
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pattern[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rate_out    <= 4'd0;
      gate        <= 1'b0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      pre         <= '0;
      cnt         <= 9'd0;
    end else begin
      step_strobe <= 1'b0;
      if (!run) begin
        state    <= S_IDLE;
        gate     <= 1'b0;
        step_idx <= '0;
        pre      <= '0;
        cnt      <= 9'd0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state <= S_LOAD;
          end
          S_LOAD: begin
            rate_out    <= entry[3:0];
            gate        <= ~entry[4];
            step_strobe <= 1'b1;
            pre         <= '0;
            cnt         <= 9'd0;
            state       <= S_HOLD;
          end
          S_HOLD: begin
            if (tick) begin
              pre <= '0;
              cnt <= cnt + 9'd1;
              if (last) begin
                gate <= 1'b0;
`ifdef SEQ_GAP_EN
                state <= S_GAP;
`else
                step_idx <= step_idx + IW'(1);
                state    <= S_LOAD;
`endif
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
`ifdef SEQ_GAP_EN
          S_GAP: begin
            if (tick) begin
              pre      <= '0;
              step_idx <= step_idx + IW'(1);
              state    <= S_LOAD;
            end else begin
              pre <= pre + PW'(1);
            end
          end
`endif
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
